// File: rtl/aes_pkg.sv
// Shared AES widths and the inv_subbytes_seq FSM encoding.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_NBYTES  = 16;
  localparam int AES_BYTE_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } isb_state_e;

endpackage

// File: rtl/inv_sbox.sv
// AES inverse S-box with one registered cycle of latency: inverse affine
// map followed by the GF(2^8) multiplicative inverse (x^254).
module inv_sbox (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  logic [7:0] out_q, out_d;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Square-and-multiply: accumulates x^2 * x^4 * ... * x^128 = x^254, and 0 maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = x;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction

  always_comb begin
    out_d = gf_inv(inv_affine(in_byte));
  end

  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign out_byte = out_q;

endmodule

// File: rtl/inv_subbytes_seq.sv
// Sequential AES InvSubBytes over one time-shared inv_sbox lane.
// Define INV_SUBBYTES_TWO_LANE_EN for two lanes (8 RUN cycles instead of 16).
module inv_subbytes_seq
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic                   busy
);

`ifdef INV_SUBBYTES_TWO_LANE_EN
  localparam int LANES = 2;
`else
  localparam int LANES = 1;
`endif
  localparam logic [3:0] LAST_CNT = 4'(AES_NBYTES / LANES - 1);

  isb_state_e             state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [AES_STATE_W-1:0] blk_q, blk_d;
  logic [AES_STATE_W-1:0] res_q, res_d;
  logic                   out_valid_q, out_valid_d;
  logic [AES_BYTE_W-1:0]  sb_in  [LANES];
  logic [AES_BYTE_W-1:0]  sb_out [LANES];
  logic [3:0]             wr_base;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    inv_sbox u_inv_sbox (
      .clk      (clk),
      .rst      (~rst_n),
      .in_byte  (sb_in[l]),
      .out_byte (sb_out[l])
    );
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    blk_d       = blk_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    // Lookup results land one cycle after their byte was driven, so RUN
    // writes the previous group and DRAIN writes the final group.
    wr_base     = (state_q == ST_DRAIN) ? cnt_q : cnt_q - 4'd1;

    for (int l = 0; l < LANES; l++) begin
      sb_in[l] = blk_q[(int'(cnt_q) * LANES + l) * AES_BYTE_W +: AES_BYTE_W];
    end

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          blk_d   = in_state;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q != 4'd0) begin
          for (int l = 0; l < LANES; l++) begin
            res_d[(int'(wr_base) * LANES + l) * AES_BYTE_W +: AES_BYTE_W] = sb_out[l];
          end
        end
        if (cnt_q == LAST_CNT) state_d = ST_DRAIN;
        else                   cnt_d   = cnt_q + 4'd1;
      end
      ST_DRAIN: begin
        for (int l = 0; l < LANES; l++) begin
          res_d[(int'(wr_base) * LANES + l) * AES_BYTE_W +: AES_BYTE_W] = sb_out[l];
        end
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      blk_q       <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      blk_q       <= blk_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_state = res_q;

endmodule

// File: doc/inv_subbytes_seq.md
INV_SUBBYTES_SEQ -- requirements
Module: inv_subbytes_seq

Interface
REQ-001 The block SHALL have no parameters; widths are fixed by package constants.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  in_state holds a block to transform.
REQ-005 in_ready  output  1  block can accept a block; high only in IDLE.
REQ-006 in_state  input  128  input block; byte i = in_state[8i+7:8i].
REQ-007 out_valid  output  1  out_state holds a completed block.
REQ-008 out_ready  input  1  downstream accepts out_state.
REQ-009 out_state  output  128  inverse-S-box of each input byte, same byte positions.
REQ-010 busy  output  1  high in any state other than IDLE.

Function
REQ-011 The block SHALL time-share one inv_sbox lookup (1-cycle registered latency) across all 16 bytes.
REQ-012 FSM states: IDLE, RUN, DRAIN, DONE; encoding from package enum.
REQ-013 IDLE: in_ready=1; on in_valid&&in_ready, capture in_state, clear cnt to 0, go to RUN.
REQ-014 RUN: drive byte[cnt] to the lookup and increment cnt; when cnt==15, go to DRAIN.
REQ-015 The lookup result for byte k SHALL be written to result byte k two edges after byte k is driven; writes follow a lagged index (cnt-1).
REQ-016 DRAIN: capture byte 15 result, set out_valid, go to DONE.
REQ-017 DONE: hold out_valid=1 and out_state stable until out_ready=1; on that edge clear out_valid and go to IDLE.
REQ-018 Latency: with accept at edge T, out_valid SHALL first be high after edge T+17.
REQ-019 in_ready SHALL be combinational from state only (no in_valid→in_ready path); no accept can occur in RUN, DRAIN or DONE.
REQ-020 in_state changes after the accept edge SHALL NOT affect the result.
REQ-021 out_ready while out_valid=0 SHALL be ignored.
REQ-022 cnt SHALL be 4 bits and SHALL NOT wrap during RUN; it is don't-care outside RUN.

Reset
REQ-023 rst_n low, asynchronously: state=IDLE, cnt=0, out_valid=0, out_state=0, captured block=0, busy=0.
REQ-024 Reset asserted mid-RUN/DRAIN/DONE SHALL abandon the block; no out_valid follows reset release.
REQ-025 The inv_sbox instance's synchronous rst SHALL be driven by ~rst_n; its output is used only inside RUN/DRAIN.

Configuration
REQ-026 Macro INV_SUBBYTES_TWO_LANE_EN: when defined, two inv_sbox instances process bytes 2j and 2j+1 per cycle, RUN lasts 8 cycles (cnt 0..7), and latency is 9 (out_valid after edge T+9).
REQ-027 Without INV_SUBBYTES_TWO_LANE_EN: one lane, 16 RUN cycles, latency 17 as in REQ-018.
REQ-028 Interface and handshake rules SHALL be identical in both builds.

Structure
REQ-029 Shared package aes_pkg SHALL hold AES_STATE_W=128, AES_NBYTES=16, AES_BYTE_W=8 and the inv_subbytes_seq FSM state enum.
REQ-030 The lookup SHALL be the existing inv_sbox sub-module, instantiated once (twice with INV_SUBBYTES_TWO_LANE_EN); the block contains no S-box table itself.

Verification
REQ-031 in_state=128'h0, out_ready=1 -> out_state=all bytes 0x52, out_valid exactly 17 cycles after accept (9 with TWO_LANE).
REQ-032 in_state=all bytes 0x63 -> out_state=128'h0.
REQ-033 in_state=128'h0f0e0d0c0b0a09080706050403020100 -> out_state=128'hfbd7f3819ea340bf38a53630d56a0952 (byte-order check).
REQ-034 out_ready=0 for 5 cycles after out_valid -> out_state stable, out_valid held, in_ready=0, busy=1; completes on first out_ready=1.
REQ-035 rst_n pulsed low at cnt=7 in RUN -> outputs reset immediately; next accepted block produces correct result, no stale out_valid.
REQ-036 16 back-to-back blocks covering byte values 0x00..0xFF, random out_ready -> every byte matches the FIPS-197 inverse S-box golden table.
